acc_control: RTL

ACC_CONTROL -- requirements
Module: acc_control

---
 rtl/acc_control_pkg.sv | 10 +
 rtl/acc_control.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/acc_control_pkg.sv
// rtl/acc_control_pkg.sv - shared dsp accumulator control types and constants
package acc_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } acc_state_t;

endpackage : acc_control_pkg

// File: rtl/acc_control.sv
// rtl/acc_control.sv - frame-aligned sample forwarder driving a downstream accumulator
module acc_control
  import acc_control_pkg::*;
#(
  parameter int DIN_WIDTH = 16,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 sync,
  input  logic [LEN_WIDTH-1:0] acc_len,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 acc_done,
  output logic                 first_frame,
  output logic                 armed
);

  acc_state_t           r_state;
  logic                 r_pending;
  logic [LEN_WIDTH-1:0] r_idx;
  logic [LEN_WIDTH-1:0] r_len_l;
  logic                 r_in_first;
  logic [DIN_WIDTH-1:0] r_dout;
  logic                 r_dout_valid;
  logic                 r_acc_done;
  logic                 r_first_frame;

  acc_state_t           w_state_nxt;
  logic                 w_pending_nxt;
  logic [LEN_WIDTH-1:0] w_idx_nxt;
  logic [LEN_WIDTH-1:0] w_len_nxt;
  logic                 w_in_first_nxt;
  logic                 w_fwd;
  logic                 w_resync;
  logic                 w_index0;
  logic                 w_acc_done_nxt;
  logic                 w_first_nxt;
  logic [LEN_WIDTH-1:0] w_len_eff;
  logic [LEN_WIDTH-1:0] w_cur_len;
  logic [LEN_WIDTH-1:0] w_cur_idx;

  // Next-state, frame index and output qualifiers for the sample presented this cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_idx_nxt      = r_idx;
    w_len_nxt      = r_len_l;
    w_in_first_nxt = r_in_first;
    w_fwd          = 1'b0;
    w_resync       = 1'b0;
    w_index0       = 1'b0;
    w_acc_done_nxt = 1'b0;
    w_first_nxt    = 1'b0;
    w_len_eff      = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
    w_cur_len      = r_len_l;
    w_cur_idx      = r_idx;

    if (disarm) begin
      // disarm beats arm, sync and din_valid; the sample this cycle is dropped
      w_state_nxt    = ST_IDLE;
      w_pending_nxt  = 1'b0;
      w_idx_nxt      = '0;
      w_in_first_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pending_nxt = 1'b0;
          if (arm) begin
            w_state_nxt = ST_WAIT_SYNC;
          end
        end
        ST_WAIT_SYNC: begin
          if (din_valid && (sync || r_pending)) begin
            w_state_nxt = ST_RUN;
            w_fwd       = 1'b1;
            w_resync    = 1'b1;
          end else if (sync) begin
            w_pending_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          if (din_valid) begin
            w_fwd    = 1'b1;
            w_resync = sync || r_pending;
          end else if (sync) begin
            w_pending_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      if (w_fwd) begin
        // A resync or a wrapped counter makes this sample index 0 and relatches the length
        w_index0      = w_resync || (r_idx == '0);
        w_cur_len     = w_index0 ? w_len_eff : r_len_l;
        w_cur_idx     = w_index0 ? '0 : r_idx;
        w_len_nxt     = w_cur_len;
        // w_cur_len is never 0, so len-1 cannot underflow and idx+1 cannot overflow
        w_idx_nxt     = (w_cur_idx == w_cur_len - LEN_WIDTH'(1)) ? '0
                                                                 : w_cur_idx + LEN_WIDTH'(1);
        w_pending_nxt = 1'b0;
        w_acc_done_nxt = w_index0;
        if (w_resync) begin
          w_in_first_nxt = 1'b1;
        end else if (w_index0) begin
          w_in_first_nxt = 1'b0;
        end
        w_first_nxt = w_in_first_nxt;
      end
    end
  end

  // State, counters and registered outputs; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pending     <= 1'b0;
      r_idx         <= '0;
      r_len_l       <= LEN_WIDTH'(1);
      r_in_first    <= 1'b0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_acc_done    <= 1'b0;
      r_first_frame <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_idx         <= w_idx_nxt;
      r_len_l       <= w_len_nxt;
      r_in_first    <= w_in_first_nxt;
      r_dout        <= din;
      r_dout_valid  <= w_fwd;
      r_acc_done    <= w_acc_done_nxt;
      r_first_frame <= w_first_nxt;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign acc_done    = r_acc_done;
  assign first_frame = r_first_frame;
  assign armed       = (r_state != ST_IDLE);

endmodule : acc_control
